// File: rtl/doodle_physics.sv
// doodle_physics: per-frame doodle position/velocity integrator with bounce and freeze.
// Optional DOODLE_X_CLAMP_EN replaces horizontal wrap with clamping to 0..SCREEN_WIDTH-40.
module doodle_physics #(
  parameter int EARTH         = 460,
  parameter int DOODLE_HEIGHT = 40,
  parameter int SCREEN_WIDTH  = 640,
  parameter int START_X       = 300,
  parameter int START_Y       = 400,
  parameter int JUMP_VELOCITY = 12,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calculation_time,
  input  logic signed [8:0] delta_x,
  input  logic [1:0]        game_state,
  input  logic              on_platform,
  output logic [9:0]        doodle_x,
  output logic [9:0]        doodle_y,
  output logic signed [5:0] velocity_y,
  output logic              jump_pulse
);
  typedef enum logic {AIR, FROZEN} state_t;
  state_t state, state_nx;
  logic signed [11:0] cand_y, nx;
  logic earth, bounce, pulse_nx;
  logic [9:0] y_sat, x_new, x_nx, y_nx;
  logic signed [5:0] v_fall, v_nx;
  always_comb begin
    cand_y = signed'({2'b00, doodle_y}) + 12'(velocity_y);
    nx = signed'({2'b00, doodle_x}) + 12'(delta_x);
    earth = game_state == 2'd0 && cand_y + 12'(DOODLE_HEIGHT) >= 12'(EARTH);
    bounce = velocity_y > 6'sd0 && (on_platform || earth);
    y_sat = cand_y < 12'sd0 ? 10'd0 : cand_y > 12'sd1023 ? 10'd1023 : cand_y[9:0];
    v_fall = velocity_y >= 6'(MAX_FALL) ? 6'(MAX_FALL) : velocity_y + 6'(GRAVITY);
`ifdef DOODLE_X_CLAMP_EN
    x_new = nx < 12'sd0 ? 10'd0 : nx > 12'(SCREEN_WIDTH - 40) ? 10'(SCREEN_WIDTH - 40) : nx[9:0];
`else
    x_new = nx < 12'sd0 ? 10'(nx + 12'(SCREEN_WIDTH)) :
            nx >= 12'(SCREEN_WIDTH) ? 10'(nx - 12'(SCREEN_WIDTH)) : nx[9:0];
`endif
    state_nx = state;
    x_nx = doodle_x;
    y_nx = doodle_y;
    v_nx = velocity_y;
    pulse_nx = 1'b0;
    // game_state 2 or 3 freezes before any motion, so a coincident bounce is dropped
    if (calculation_time && state == AIR) begin
      if (game_state[1]) state_nx = FROZEN;
      else begin
        x_nx = x_new;
        y_nx = bounce && earth ? 10'(EARTH - DOODLE_HEIGHT) : y_sat;
        v_nx = bounce ? -6'(JUMP_VELOCITY) : v_fall;
        pulse_nx = bounce;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= AIR;
      doodle_x <= 10'(START_X);
      doodle_y <= 10'(START_Y);
      velocity_y <= 6'sd0;
      jump_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      doodle_x <= x_nx;
      doodle_y <= y_nx;
      velocity_y <= v_nx;
      jump_pulse <= pulse_nx;
    end
endmodule

// File: tb/tb_doodle_physics.sv
// tb_doodle_physics: randomized + directed bench against an integer reference model.
module tb_doodle_physics;
  logic clk = 0, rst = 1, cal = 0, on_platform = 0;
  logic signed [8:0] delta_x = 0;
  logic [1:0] game_state = 0;
  logic [9:0] doodle_x, doodle_y;
  logic signed [5:0] velocity_y;
  logic jump_pulse;
  int n_chk = 0, n_fail = 0, pulse_cnt = 0, pc0;
  bit chk = 0;
  int mx, my, mv, mp, mf, cy, nx;
  bit mearth;

  doodle_physics dut (.clk(clk), .rst(rst), .calculation_time(cal), .delta_x(delta_x),
    .game_state(game_state), .on_platform(on_platform), .doodle_x(doodle_x),
    .doodle_y(doodle_y), .velocity_y(velocity_y), .jump_pulse(jump_pulse));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      mx = 300; my = 400; mv = 0; mp = 0; mf = 0;
    end else begin
      mp = 0;
      if (cal && !mf) begin
        if (game_state >= 2) mf = 1;
        else begin
          cy = my + mv;
          mearth = game_state == 0 && cy + 40 >= 460;
          if (mv > 0 && (on_platform || mearth)) begin
            my = mearth ? 420 : sat(cy, 0, 1023);
            mv = -12;
            mp = 1;
          end else begin
            my = sat(cy, 0, 1023);
            mv = mv + 1 > 15 ? 15 : mv + 1;
          end
          nx = mx + int'(delta_x);
`ifdef DOODLE_X_CLAMP_EN
          mx = sat(nx, 0, 600);
`else
          mx = ((nx % 640) + 640) % 640;
`endif
        end
      end
    end

  always @(negedge clk) begin
    if (jump_pulse) pulse_cnt++;
    if (chk) begin
      check("x", int'(doodle_x), mx);
      check("y", int'(doodle_y), my);
      check("vel", int'(velocity_y), mv);
      check("pulse", int'(jump_pulse), mp);
    end
  end

  task automatic tick(input int gs, input int dx, input bit onp);
    @(posedge clk); #2;
    cal = 1; game_state = gs[1:0]; delta_x = dx[8:0]; on_platform = onp;
    @(posedge clk); #2;
    cal = 0; on_platform = 0; delta_x = 0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  int ey[9] = '{400, 401, 403, 406, 410, 415, 420, 408, 397};
  int ev[9] = '{1, 2, 3, 4, 5, 6, -12, -11, -10};
  int wdx[8] = '{255, 75, 15, -3, -5, -256, -256, -256};
`ifdef DOODLE_X_CLAMP_EN
  int wex[8] = '{555, 600, 600, 597, 592, 336, 80, 0};
`else
  int wex[8] = '{555, 630, 5, 2, 637, 381, 125, 509};
`endif

  initial begin
    #1 rst = 0;
    #3;
    check("reset_x", int'(doodle_x), 300);
    check("reset_y", int'(doodle_y), 400);
    check("reset_v", int'(velocity_y), 0);
    check("reset_pulse", int'(jump_pulse), 0);
    chk = 1;
    @(posedge clk); #2 rst = 1;
    for (int i = 0; i < 9; i++) begin
      tick(0, 0, 0);
      check($sformatf("earth_y%0d", i), int'(doodle_y), ey[i]);
      check($sformatf("earth_v%0d", i), int'(velocity_y), ev[i]);
      if (i == 6) check("earth_pulse_cnt", pulse_cnt, 1);
    end
    repeat (7) tick(0, 0, 0);
    tick(0, 0, 1);
    check("plat_up_y", int'(doodle_y), 345);
    check("plat_up_v", int'(velocity_y), -2);
    check("plat_up_pulse_cnt", pulse_cnt, 1);
    repeat (6) tick(0, 0, 0);
    check("plat_pre_v", int'(velocity_y), 4);
    tick(0, 0, 1);
    check("plat_y", int'(doodle_y), 352);
    check("plat_v", int'(velocity_y), -12);
    check("plat_pulse_cnt", pulse_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      tick(0, wdx[i], 0);
      check($sformatf("wrap_x%0d", i), int'(doodle_x), wex[i]);
    end
    repeat (600) begin
      @(posedge clk); #2;
      cal = ($urandom % 3) == 0;
      game_state = 2'($urandom % 2);
      delta_x = 9'($urandom_range(0, 511));
      on_platform = ($urandom % 4) == 0;
    end
    cal = 0; on_platform = 0; delta_x = 0;
    repeat (100) tick(1, 0, 0);
    check("fall_v", int'(velocity_y), 15);
    check("fall_y", int'(doodle_y), 1023);
    @(posedge clk); #3 rst = 0;
    #1;
    check("async_x", int'(doodle_x), 300);
    check("async_y", int'(doodle_y), 400);
    check("async_v", int'(velocity_y), 0);
    check("async_pulse", int'(jump_pulse), 0);
    @(posedge clk); #2 rst = 1;
    repeat (6) tick(0, 0, 0);
    pc0 = pulse_cnt;
    tick(2, 0, 0);
    check("freeze_y", int'(doodle_y), 415);
    check("freeze_v", int'(velocity_y), 6);
    check("freeze_pulse_cnt", pulse_cnt, pc0);
    repeat (3) tick(0, 5, 1);
    check("frozen_x", int'(doodle_x), 300);
    check("frozen_y", int'(doodle_y), 415);
    check("frozen_v", int'(velocity_y), 6);
    check("frozen_pulse_cnt", pulse_cnt, pc0);
    @(negedge clk);
    chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/doodle_physics.md
Name: doodle_physics

Overview:
- Consumer of the horizontal step (delta_x) and game phase (game_state) from the game-control block.
- Integrates doodle position and vertical velocity on every calculation_time strobe.
- Produces doodle_y, which closes the loop back to the control block's fall-to-earth check, and doodle_x for rendering.
- Sits between control and the renderer/platform-collision logic.

Parameters:
- EARTH, 460, signed y coordinate of ground line (doodle feet).
- DOODLE_HEIGHT, 40, sprite height in pixels.
- SCREEN_WIDTH, 640, horizontal wrap modulus.
- START_X, 300, reset x.
- START_Y, 400, reset y (top of sprite).
- JUMP_VELOCITY, 12, upward speed applied on a bounce, in px/tick.
- GRAVITY, 1, velocity increment per tick.
- MAX_FALL, 15, downward velocity cap.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- calculation_time  in  1  one-cycle update strobe (once per frame).
- delta_x  in  9 signed  horizontal step for this tick.
- game_state  in  2  0 = waiting, 1 = playing, 2 = game over.
- on_platform  in  1  from the collision block; doodle feet overlap a platform top.
- doodle_x  out  10  sprite left x, range 0..SCREEN_WIDTH-1.
- doodle_y  out  10  sprite top y.
- velocity_y  out  6 signed  vertical velocity; positive = down.
- jump_pulse  out  1  one clk cycle high on each bounce.

Behaviour:
- Reset (rst low, async): doodle_x=START_X, doodle_y=START_Y, velocity_y=0, jump_pulse=0, FSM=AIR.
- Timing: all state updates only on a clk edge with calculation_time=1. Outputs are registered and change one clk after the strobe. jump_pulse is otherwise 0 and clears the next clk.
- FSM states:
  - AIR: normal motion.
  - FROZEN: entered when game_state==2 at a strobe. Outputs hold. Leaves only via reset.
  - game_state==3 behaves as 2.
- Vertical update per tick, in AIR:
  - cand_y = doodle_y + velocity_y, computed in 12-bit signed.
  - Bounce condition: velocity_y > 0, AND either:
    - on_platform=1, or
    - game_state==0 and cand_y + DOODLE_HEIGHT >= EARTH.
  - On bounce:
    - doodle_y = EARTH - DOODLE_HEIGHT for the earth case, or cand_y for the platform case.
    - velocity_y = -JUMP_VELOCITY.
    - jump_pulse=1.
  - Otherwise:
    - doodle_y = cand_y saturated to 0..1023.
    - velocity_y = min(velocity_y + GRAVITY, MAX_FALL).
- Earth is solid only in game_state 0. In game_state 1 the doodle falls through EARTH, so the control block detects game over.
- Horizontal update per tick, in AIR with game_state!=2:
  - nx = doodle_x + delta_x, in 12-bit signed.
  - If nx < 0: nx += SCREEN_WIDTH. If nx >= SCREEN_WIDTH: nx -= SCREEN_WIDTH.
  - |delta_x| < SCREEN_WIDTH is guaranteed by the producer.
- Simultaneous events:
  - game_state==2 and a bounce condition on the same strobe: freeze wins, no pulse.
  - on_platform with velocity_y <= 0: ignored, so the doodle passes up through platforms.
- No update and no pulse without calculation_time, regardless of inputs.

Optional Feature:
- Macro DOODLE_X_CLAMP_EN.
- Defined: no horizontal wrap. doodle_x is clamped to 0..SCREEN_WIDTH-DOODLE_WIDTH_FIXED, where the upper bound is SCREEN_WIDTH-40.
- Undefined: wrap-around as specified above.

Test Plan:
- Reset, game_state=0, delta_x=0, strobe every 4 clk:
  - y sequence 400,401,403,406,410,415; velocity 1..6.
  - 7th strobe: y=420, velocity=-12, jump_pulse high exactly 1 clk.
  - Next strobes: y=408, 397.
- Wrap: x=630, delta_x=+15 -> x=5. x=2, delta_x=-5 -> x=637. With DOODLE_X_CLAMP_EN: 600 and 0 respectively.
- game_state=1 while falling past EARTH: no bounce, y keeps increasing, velocity saturates at 15 and stays there.
- on_platform=1 with velocity=+4, y=200 -> y=204, velocity=-12, pulse. on_platform=1 with velocity=-3 -> ignored, y decreases by 3.
- game_state=2 coincident with an earth bounce -> outputs frozen, no pulse; further strobes and delta_x=+5 change nothing.
- rst asserted low mid-clk between strobes -> outputs go to 300/400/0/0 immediately, without waiting for a clk edge.
